register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32 x 32-bit RISC-V integer register file with two combinational read ports and one synchronous write port.
- Sits in the core datapath between decode (rs1/rs2/rd addresses) and execute/writeback.
- x0 is hardwired to zero.
- Reset loads a deterministic, non-zero pattern into x1..x31 so that software and benches have known initial operands.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers.
- ADDR_WIDTH, 5, address width; must equal clog2(NUM_REGS).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- reg_wr  input  1  write enable.
- raddr1  input  ADDR_WIDTH  read port 1 address (rs1).
- raddr2  input  ADDR_WIDTH  read port 2 address (rs2).
- waddr  input  ADDR_WIDTH  write address (rd).
- wdata  input  DATA_WIDTH  write data.
- rdata1  output  DATA_WIDTH  read port 1 data.
- rdata2  output  DATA_WIDTH  read port 2 data.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset, sampled at posedge clk with rst=1:
  - x0 = 0.
  - xi = 10*i for i = 1..31, truncated to DATA_WIDTH. Examples: x1 = 32'd10, x3 = 32'd30, x31 = 32'd310.
- Reset has priority over a simultaneous write; reg_wr is ignored while rst=1.
- Write: at posedge clk with rst=0 and reg_wr=1, reg[waddr] <= wdata, provided waddr != 0.
  - A write to x0 is discarded silently.
  - reg_wr=0 leaves all registers unchanged regardless of waddr/wdata.
- Read: purely combinational, zero latency.
  - rdataN = reg[raddrN].
  - Address 0 always returns 0, independent of storage contents.
- Both read ports are independent; both may address the same register.
- Read-during-write, same address, without the optional feature: read returns the old value until the clock edge, and the new value after it.
- Outputs carry no reset of their own; they follow the register contents combinationally. Immediately after the reset edge, rdata reflects the reset pattern.
- Reset asserted mid-operation: the next posedge restores the full reset pattern, discarding all prior writes.
- No X on outputs after the first reset edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When reg_wr=1, rst=0, waddr != 0 and raddrN == waddr, rdataN = wdata combinationally in the same cycle. Storage update is unchanged. x0 reads still return 0.
- Not defined: no forwarding; same-cycle reads return the stored (old) value.

Decomposition:
- Package regfile_pkg holds:
  - DATA_WIDTH, NUM_REGS, ADDR_WIDTH defaults.
  - typedefs reg_addr_t (logic [ADDR_WIDTH-1:0]) and reg_data_t (logic [DATA_WIDTH-1:0]).
  - function reset_value(idx) returning 10*idx, or 0 for idx 0.
- One natural sub-module: register_file_read_port.
  - Performs the address-0 zero check, the mux, and the optional bypass compare.
  - Instantiated twice, once per read port.

Test Plan:
- Reset: rst=1 for one edge, then rst=0; read raddr1=0, raddr2=1 -> rdata1=0, rdata2=32'd10. Also read x3 -> 32'd30 and x31 -> 32'd310.
- Write disabled: waddr=3, wdata=32'hDEADBEEF, reg_wr=0, one clock; read x3 -> 32'd30.
- Write: waddr=2, wdata=32'h11112222, reg_wr=1, one clock, then reg_wr=0; read x2 and x1 -> 32'h11112222 and 32'd10.
- x0 protection: waddr=0, wdata=32'hFFFFFFFF, reg_wr=1, one clock; read x0 and x2 -> 0 and 32'h11112222.
- Reset mid-operation: write x5=32'hA5A5A5A5, then assert rst with reg_wr=1, waddr=5 on the same edge; read x5 -> 32'd50.
- Same-cycle read of waddr=7 with reg_wr=1, wdata=32'h12345678:
  - Before the edge: rdata = 32'd70 without REGFILE_BYPASS_EN, 32'h12345678 with it.
  - After the edge: 32'h12345678 in both builds.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizes, types and reset pattern for the integer register file
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_REGS   = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

    // Known non-zero operands after reset: xi = 10*i, x0 stays zero.
    function automatic reg_data_t reset_value(input int idx);
        if (idx == 0) begin
            return '0;
        end
        return reg_data_t'(10 * idx);
    endfunction

endpackage

// File: rtl/register_file_read_port.sv
// rtl/register_file_read_port.sv - one combinational read port with x0 masking and write-through compare
module register_file_read_port #(
    parameter int DATA_WIDTH = regfile_pkg::DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = regfile_pkg::DEFAULT_NUM_REGS,
    parameter int ADDR_WIDTH = regfile_pkg::DEFAULT_ADDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  byp_en,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    always_comb begin
        rdata = regs[raddr];
        if (raddr == '0) begin
            rdata = '0;
        end else if (byp_en && (raddr == waddr)) begin
            rdata = wdata;
        end
    end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 integer register file, 2 read / 1 write; REGFILE_BYPASS_EN enables write-through forwarding
module register_file #(
    parameter int DATA_WIDTH = regfile_pkg::DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = regfile_pkg::DEFAULT_NUM_REGS,
    parameter int ADDR_WIDTH = regfile_pkg::DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_wr,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2
);

    import regfile_pkg::*;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  byp_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_WIDTH'(reset_value(i));
            end
        end else if (reg_wr && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign byp_en = reg_wr && !rst && (waddr != '0);
`else
    assign byp_en = 1'b0;
`endif

    register_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd1 (
        .regs   (regs),
        .raddr  (raddr1),
        .byp_en (byp_en),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata1)
    );

    register_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd2 (
        .regs   (regs),
        .raddr  (raddr2),
        .byp_en (byp_en),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata2)
    );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed and randomized checks of register_file against an array model
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        reg_wr;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    logic [31:0] model [32];
    bit          checking;
    int          checks;
    int          errors;

    register_file dut (
        .clk    (clk),
        .rst    (rst),
        .reg_wr (reg_wr),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // What a read of address a must return right now, from the architectural rules.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (reg_wr && !rst && waddr != 5'd0 && a == waddr) return wdata;
`endif
        return model[a];
    endfunction

    // One clock edge: model follows the inputs sampled at the edge, then inputs may change.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'(10 * i);
        end else if (reg_wr && waddr != 5'd0) begin
            model[waddr] = wdata;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("model_rd1", rdata1, exp_read(raddr1));
            check("model_rd2", rdata2, exp_read(raddr2));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        checking = 0;
        rst = 1'b1;
        reg_wr = 1'b0;
        raddr1 = '0;
        raddr2 = '0;
        waddr = '0;
        wdata = '0;

        step();
        rst = 1'b0;
        checking = 1;
        raddr1 = 5'd0; raddr2 = 5'd1;
        #1 check("reset_x0", rdata1, 32'd0);
        check("reset_x1", rdata2, 32'd10);
        raddr1 = 5'd3; raddr2 = 5'd31;
        #1 check("reset_x3", rdata1, 32'd30);
        check("reset_x31", rdata2, 32'd310);

        waddr = 5'd3; wdata = 32'hDEADBEEF; reg_wr = 1'b0;
        step();
        raddr1 = 5'd3;
        #1 check("wr_disabled_x3", rdata1, 32'd30);

        waddr = 5'd2; wdata = 32'h11112222; reg_wr = 1'b1;
        step();
        reg_wr = 1'b0;
        raddr1 = 5'd2; raddr2 = 5'd1;
        #1 check("write_x2", rdata1, 32'h11112222);
        check("write_x1_kept", rdata2, 32'd10);

        waddr = 5'd0; wdata = 32'hFFFFFFFF; reg_wr = 1'b1;
        step();
        reg_wr = 1'b0;
        raddr1 = 5'd0; raddr2 = 5'd2;
        #1 check("x0_protect", rdata1, 32'd0);
        check("x0_protect_x2", rdata2, 32'h11112222);

        waddr = 5'd5; wdata = 32'hA5A5A5A5; reg_wr = 1'b1;
        step();
        reg_wr = 1'b0;
        raddr1 = 5'd5;
        #1 check("write_x5", rdata1, 32'hA5A5A5A5);
        rst = 1'b1; reg_wr = 1'b1; waddr = 5'd5; wdata = 32'h0BADF00D;
        step();
        rst = 1'b0; reg_wr = 1'b0;
        raddr1 = 5'd5; raddr2 = 5'd2;
        #1 check("midreset_x5", rdata1, 32'd50);
        check("midreset_x2", rdata2, 32'd20);

        raddr1 = 5'd7; raddr2 = 5'd7; waddr = 5'd7; wdata = 32'h12345678; reg_wr = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_before", rdata1, 32'h12345678);
`else
        check("rdw_before", rdata1, 32'd70);
`endif
        step();
        reg_wr = 1'b0;
        #1 check("rdw_after", rdata2, 32'h12345678);

        for (int n = 0; n < 3000; n++) begin
            rst    = ($urandom_range(0, 59) == 0);
            reg_wr = $urandom_range(0, 1);
            waddr  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            wdata  = $urandom;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            step();
        end
        rst = 1'b0;
        reg_wr = 1'b0;
        step();
        checking = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
